// File: rtl/pfpu_vseq.sv
// Vertex sequencer for the programmable FPU: steps a mesh in row-major order,
// running the per-vertex program, waiting out the pipeline drain and handing each vertex to the sink.
module pfpu_vseq #(
    parameter int DRAIN = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [10:0] prog_len,
    input  logic [6:0]  hmeshlast,
    input  logic [6:0]  vmeshlast,
    input  logic [10:0] pc,
    output logic        count_rst,
    output logic        issue_en,
    output logic [6:0]  vx,
    output logic [6:0]  vy,
    output logic        vout_valid,
    input  logic        vout_ready,
    output logic        busy,
    output logic        irq,
    output logic [13:0] vertex_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_EMIT} state_t;

    localparam logic [7:0] DRAIN_LD = 8'(DRAIN);

    state_t      r_state;
    state_t      w_next;
    logic [10:0] r_n;
    logic [6:0]  r_hlast;
    logic [6:0]  r_vlast;
    logic [6:0]  r_vx;
    logic [6:0]  r_vy;
    logic [13:0] r_cnt;
    logic [7:0]  r_drain;
    logic        r_issue;
    logic        r_irq;
    logic        w_start;
    logic        w_xfer;
    logic        w_last;

    always_comb begin
        w_next  = r_state;
        w_start = (r_state == S_IDLE) && start && (prog_len != 11'd0);
        // abort wins over a transfer in the same cycle
        w_xfer  = (r_state == S_EMIT) && vout_ready && !abort;
        w_last  = (r_vx == r_hlast) && (r_vy == r_vlast);
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_RUN;
            S_RUN:   if (pc == r_n - 11'd1) w_next = S_DRAIN;
            S_DRAIN: if (r_drain == 8'd1) w_next = S_EMIT;
            S_EMIT:  if (w_xfer) w_next = w_last ? S_IDLE : S_RUN;
            default: w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE))
            w_next = S_IDLE;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_n     <= 11'd0;
            r_hlast <= 7'd0;
            r_vlast <= 7'd0;
            r_vx    <= 7'd0;
            r_vy    <= 7'd0;
            r_cnt   <= 14'd0;
            r_drain <= 8'd0;
            r_issue <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_next;
            // program memory has one cycle of read latency
            r_issue <= (r_state == S_RUN);
            r_irq   <= w_xfer && w_last;
            if (w_start) begin
                r_n     <= prog_len;
                r_hlast <= hmeshlast;
                r_vlast <= vmeshlast;
                r_vx    <= 7'd0;
                r_vy    <= 7'd0;
                r_cnt   <= 14'd0;
            end
            if ((r_state == S_RUN) && (w_next == S_DRAIN))
                r_drain <= DRAIN_LD;
            else if ((r_state == S_DRAIN) && (r_drain != 8'd0))
                r_drain <= r_drain - 8'd1;
            if (w_xfer) begin
                if (r_cnt != 14'h3FFF)
                    r_cnt <= r_cnt + 14'd1;
                if (!w_last) begin
                    if (r_vx == r_hlast) begin
                        r_vx <= 7'd0;
                        r_vy <= r_vy + 7'd1;
                    end else begin
                        r_vx <= r_vx + 7'd1;
                    end
                end
            end
        end
    end

    assign count_rst  = (r_state != S_RUN);
    assign issue_en   = r_issue;
    assign vx         = r_vx;
    assign vy         = r_vy;
    assign vout_valid = (r_state == S_EMIT);
    assign busy       = (r_state != S_IDLE);
    assign irq        = r_irq;
    assign vertex_cnt = r_cnt;

endmodule

// File: tb/tb_pfpu_vseq.sv
// Bench for pfpu_vseq: directed timing cases plus randomized mesh runs checked
// against a row-major vertex queue and per-vertex cycle budgets.
module tb_pfpu_vseq;

    localparam int DR = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [10:0] prog_len = 11'd0;
    logic [6:0]  hmeshlast = 7'd0;
    logic [6:0]  vmeshlast = 7'd0;
    logic [10:0] pc = 11'd0;
    logic        vout_ready = 1'b0;
    logic        count_rst, issue_en, vout_valid, busy, irq;
    logic [6:0]  vx, vy;
    logic [13:0] vertex_cnt;

    int n_pass = 0;
    int n_chk  = 0;

    pfpu_vseq #(.DRAIN(DR)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .abort(abort),
        .prog_len(prog_len), .hmeshlast(hmeshlast), .vmeshlast(vmeshlast), .pc(pc),
        .count_rst(count_rst), .issue_en(issue_en), .vx(vx), .vy(vy),
        .vout_valid(vout_valid), .vout_ready(vout_ready), .busy(busy), .irq(irq),
        .vertex_cnt(vertex_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // program memory counter: held at 0 by count_rst, otherwise free-running
    always @(posedge sys_clk) pc <= count_rst ? 11'd0 : pc + 11'd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge sys_clk);
    endtask

    function automatic logic [31:0] span(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int k = lo; k <= hi; k++) m[k] = 1'b1;
        return m;
    endfunction

    task automatic wait_valid(input int budget);
        int t = 0;
        while (!vout_valid && t < budget) begin cyc(); t++; end
        if (!vout_valid) chk("wait_valid_timeout", 0, 1);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_count_rst"}, count_rst, 1);
        chk({pfx, "_issue_en"}, issue_en, 0);
        chk({pfx, "_vout_valid"}, vout_valid, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_irq"}, irq, 0);
        chk({pfx, "_vxvy"}, {vy, vx}, 0);
        chk({pfx, "_vertex_cnt"}, vertex_cnt, 0);
    endtask

    // one-vertex run: cycle 0 is the start cycle, everything else is relative to it
    task automatic single(input int n);
        logic [31:0] m_run = '0, m_iss = '0, m_val = '0, m_irq = '0, m_busy = '0;
        int pc_bad = 0;
        hmeshlast = 7'd0; vmeshlast = 7'd0; prog_len = 11'(n); vout_ready = 1'b1; start = 1'b1;
        for (int k = 0; k <= n + DR + 3; k++) begin
            if (k > 0) begin cyc(); start = 1'b0; end
            m_run[k]  = !count_rst;
            m_iss[k]  = issue_en;
            m_val[k]  = vout_valid;
            m_irq[k]  = irq;
            m_busy[k] = busy;
            if (!count_rst && pc != 11'(k - 1)) pc_bad++;
            if (vout_valid && {vy, vx} != 14'd0) pc_bad++;
            if (k == n + DR + 2) chk($sformatf("single%0d_cnt", n), vertex_cnt, 1);
        end
        chk($sformatf("single%0d_run", n), m_run, span(1, n));
        chk($sformatf("single%0d_issue", n), m_iss, span(2, n + 1));
        chk($sformatf("single%0d_valid", n), m_val, span(n + DR + 1, n + DR + 1));
        chk($sformatf("single%0d_irq", n), m_irq, span(n + DR + 2, n + DR + 2));
        chk($sformatf("single%0d_busy", n), m_busy, span(1, n + DR + 1));
        chk($sformatf("single%0d_pc_vxy", n), pc_bad, 0);
    endtask

    // randomized mesh run against a row-major expectation queue
    task automatic rand_run(input int id, input int n, input int h, input int v, input int pct);
        logic [13:0] q[$];
        int issue_cnt = 0, rd_cnt = 0, bad = 0, irqs = 0, t = 0, total;
        logic pvalid = 1'b0;
        logic [13:0] pxy = '0, e;
        for (int y = 0; y <= v; y++)
            for (int x = 0; x <= h; x++) q.push_back({7'(y), 7'(x)});
        total = q.size();
        prog_len = 11'(n); hmeshlast = 7'(h); vmeshlast = 7'(v); vout_ready = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        while (t < 3000) begin
            if (irq) begin
                irqs++;
                chk($sformatf("r%0d_busy_at_irq", id), busy, 0);
                break;
            end
            if (issue_en) issue_cnt++;
            if (busy && !vout_valid) rd_cnt++;
            if (vout_valid) begin
                if (pvalid && {vy, vx} != pxy) bad++;
                if (!count_rst || pc != 11'd0) bad++;
            end
            pvalid = vout_valid;
            pxy = {vy, vx};
            // latched parameters must ignore these, and start is ignored while busy
            prog_len   = 11'($urandom_range(0, 20));
            hmeshlast  = 7'($urandom_range(0, 5));
            vmeshlast  = 7'($urandom_range(0, 5));
            start      = ($urandom_range(0, 9) == 0);
            vout_ready = ($urandom_range(0, 99) < pct);
            if (vout_valid && vout_ready) begin
                e = (q.size() > 0) ? q.pop_front() : 14'h3FFF;
                chk($sformatf("r%0d_order", id), {vy, vx}, e);
                chk($sformatf("r%0d_issue_n", id), issue_cnt, n);
                chk($sformatf("r%0d_run_drain", id), rd_cnt, n + DR);
                issue_cnt = 0; rd_cnt = 0; pvalid = 1'b0;
            end
            cyc();
            start = 1'b0;
            t++;
        end
        if (t >= 3000) chk($sformatf("r%0d_timeout", id), 0, 1);
        chk($sformatf("r%0d_vertex_cnt", id), vertex_cnt, total);
        for (int k = 0; k < 3; k++) begin cyc(); if (irq) irqs++; end
        chk($sformatf("r%0d_irqs", id), irqs, 1);
        chk($sformatf("r%0d_left", id), q.size(), 0);
        chk($sformatf("r%0d_hold", id), bad, 0);
    endtask

    initial begin
        repeat (2) cyc();
        chk_reset_vals("reset");
        sys_rst_n = 1'b1;
        cyc();

        single(3);
        single(1);

        // start with zero-length program is ignored
        prog_len = 11'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        begin
            int bz = 0;
            for (int k = 0; k < 3; k++) begin if (busy || irq) bz++; cyc(); end
            chk("zero_len_start", bz, 0);
        end

        // backpressure in EMIT
        hmeshlast = 7'd0; vmeshlast = 7'd0; prog_len = 11'd2; vout_ready = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        wait_valid(50);
        begin
            int bp = 0;
            for (int k = 0; k < 5; k++) begin
                if (!vout_valid || {vy, vx} != 14'd0 || !count_rst || pc != 11'd0) bp++;
                cyc();
            end
            chk("bp_hold", bp, 0);
        end
        vout_ready = 1'b1;
        cyc();
        chk("bp_irq", irq, 1);
        chk("bp_cnt", vertex_cnt, 1);

        // abort in the third RUN cycle of vertex (1,0)
        hmeshlast = 7'd1; vmeshlast = 7'd1; prog_len = 11'd5; vout_ready = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        wait_valid(50);
        repeat (3) cyc();
        chk("abort_pc", pc, 2);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_count_rst", count_rst, 1);
        chk("abort_irq", irq, 0);
        chk("abort_cnt", vertex_cnt, 1);
        chk("abort_vxy", {vy, vx}, {7'd0, 7'd1});
        begin
            int ai = 0;
            for (int k = 0; k < 4; k++) begin cyc(); if (irq || busy) ai++; end
            chk("abort_quiet", ai, 0);
        end

        // abort beats a transfer in the same cycle
        hmeshlast = 7'd0; vmeshlast = 7'd0; prog_len = 11'd2; vout_ready = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        wait_valid(50);
        vout_ready = 1'b1; abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_xfer_busy", busy, 0);
        chk("abort_xfer_cnt", vertex_cnt, 0);
        chk("abort_xfer_irq", irq, 0);
        cyc();
        chk("abort_xfer_irq2", irq, 0);

        // abort while idle does nothing
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_idle", {busy, irq, vertex_cnt}, 0);

        // reset in the middle of DRAIN
        hmeshlast = 7'd1; vmeshlast = 7'd0; prog_len = 11'd2; vout_ready = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        chk("pre_rst_drain", {busy, count_rst, vout_valid}, 3'b110);
        sys_rst_n = 1'b0;
        cyc();
        sys_rst_n = 1'b1;
        chk_reset_vals("midrst");
        single(3);

        for (int r = 0; r < 8; r++)
            rand_run(r, $urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 2),
                     (r % 2 == 0) ? 100 : 60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
